// File: rtl/mem_wb_if.sv
// mem_wb_if: MEM-to-WB bundle, MEM-side inputs plus WB writeback/forwarding outputs
interface mem_wb_if #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
);
  logic              mem_valid;
  logic              mem_reg_write;
  logic              mem_to_reg;
  logic [REG_AW-1:0] mem_rd;
  logic [2:0]        mem_funct3;
  logic [XLEN-1:0]   mem_alu_result;
  logic [XLEN-1:0]   mem_read_data;
  logic              stall;
  logic              flush;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              wb_we;
  logic              wb_valid;
  logic              misalign_err;
  logic [63:0]       retire_count;
  modport master (
    output mem_valid, mem_reg_write, mem_to_reg, mem_rd, mem_funct3, mem_alu_result, mem_read_data, stall, flush,
    input  wb_rd, wb_data, wb_we, wb_valid, misalign_err, retire_count
  );
  modport slave (
    input  mem_valid, mem_reg_write, mem_to_reg, mem_rd, mem_funct3, mem_alu_result, mem_read_data, stall, flush,
    output wb_rd, wb_data, wb_we, wb_valid, misalign_err, retire_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB register with load lane select/extension and retired-instruction counter
module mem_wb_stage #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input logic         clk,
  input logic         rst,
  mem_wb_if.slave     bus
);
  logic [2:0]        w_off;
  logic [2:0]        w_f3;
  logic [XLEN-1:0]   w_lane;
  logic [XLEN-1:0]   w_load;
  logic [XLEN-1:0]   w_fmt;
  logic              w_mis;
  logic              r_valid;
  logic              r_we;
  logic              r_mis;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_data;
  logic [63:0]       r_retire;
  assign w_off  = bus.mem_alu_result[2:0];
  assign w_f3   = bus.mem_funct3;
  assign w_lane = bus.mem_read_data >> {w_off, 3'b000};
  // funct3[2] selects zero extension; the reserved 111 just passes the whole lane
  assign w_load = w_f3[1:0] == 2'b11 ? w_lane :
                  w_f3[1:0] == 2'b00 ? {{(XLEN-8){~w_f3[2] & w_lane[7]}}, w_lane[7:0]} :
                  w_f3[1:0] == 2'b01 ? {{(XLEN-16){~w_f3[2] & w_lane[15]}}, w_lane[15:0]} :
                                       {{(XLEN-32){~w_f3[2] & w_lane[31]}}, w_lane[31:0]};
  assign w_fmt  = bus.mem_to_reg ? w_load : bus.mem_alu_result;
  assign w_mis  = bus.mem_valid & bus.mem_to_reg & (w_f3 == 3'b111 |
                  (w_f3[1:0] == 2'b01 & w_off[0]) |
                  (w_f3[1:0] == 2'b10 & |w_off[1:0]) |
                  (w_f3[1:0] == 2'b11 & |w_off));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_valid  <= 1'b0;
      r_we     <= 1'b0;
      r_mis    <= 1'b0;
      r_rd     <= '0;
      r_data   <= '0;
      r_retire <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
    end else if (bus.stall) begin
      r_mis <= 1'b0;
    end else begin
      r_valid  <= bus.mem_valid;
      r_we     <= bus.mem_valid & bus.mem_reg_write & (bus.mem_rd != '0) & ~w_mis;
      r_mis    <= w_mis;
      r_rd     <= bus.mem_rd;
      r_data   <= w_fmt;
      r_retire <= r_retire + 64'(bus.mem_valid);
    end
  assign bus.wb_valid     = r_valid;
  assign bus.wb_we        = r_we;
  assign bus.misalign_err = r_mis;
  assign bus.wb_rd        = r_rd;
  assign bus.wb_data      = r_data;
  assign bus.retire_count = r_retire;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and random stimulus against a byte-level reference model
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic        e_valid, e_we, e_mis;
  logic [4:0]  e_rd;
  logic [63:0] e_data, e_cnt;
  mem_wb_if #(.XLEN(64), .REG_AW(5)) bus ();
  mem_wb_stage #(.XLEN(64), .REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(bus.wb_valid), 64'(e_valid));
    chk({tag, ".we"}, 64'(bus.wb_we), 64'(e_we));
    chk({tag, ".mis"}, 64'(bus.misalign_err), 64'(e_mis));
    chk({tag, ".rd"}, 64'(bus.wb_rd), 64'(e_rd));
    chk({tag, ".data"}, bus.wb_data, e_data);
    chk({tag, ".cnt"}, bus.retire_count, e_cnt);
  endtask
  function automatic logic [63:0] load_val(input logic [2:0] f3, input int off, input logic [63:0] rd);
    int sz = 1 << f3[1:0];
    logic [63:0] v = '0;
    for (int i = 0; i < sz; i++)
      if (off + i < 8) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 64'd1);
    return v;
  endfunction
  task automatic model_reset();
    e_valid = 0; e_we = 0; e_mis = 0; e_rd = 0; e_data = 0; e_cnt = 0;
  endtask
  task automatic model_edge();
    int  off = int'(bus.mem_alu_result[2:0]);
    int  sz  = 1 << bus.mem_funct3[1:0];
    logic mis = bus.mem_valid && bus.mem_to_reg && (bus.mem_funct3 == 3'd7 || (off % sz) != 0);
    if (bus.flush) begin
      e_valid = 0; e_we = 0; e_mis = 0; e_rd = 0; e_data = 0;
    end else if (bus.stall) e_mis = 0;
    else begin
      e_valid = bus.mem_valid;
      e_rd    = bus.mem_rd;
      e_data  = bus.mem_to_reg ? load_val(bus.mem_funct3, off, bus.mem_read_data) : bus.mem_alu_result;
      e_we    = bus.mem_valid && bus.mem_reg_write && bus.mem_rd != 0 && !mis;
      e_mis   = mis;
      if (bus.mem_valid) e_cnt = e_cnt + 64'd1;
    end
  endtask
  task automatic drive(input logic v, input logic rw, input logic tr, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [63:0] alu, input logic [63:0] rdat, input logic st, input logic fl);
    bus.mem_valid = v; bus.mem_reg_write = rw; bus.mem_to_reg = tr; bus.mem_rd = rd;
    bus.mem_funct3 = f3; bus.mem_alu_result = alu; bus.mem_read_data = rdat; bus.stall = st; bus.flush = fl;
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask
  localparam logic [63:0] RD = 64'h8877665544332211;
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12 check_all("reset");
    @(negedge clk) rst = 1'b1;
    #1 check_all("reset_hold");
    drive(1, 1, 0, 5, 0, 64'h1234, 0, 0, 0);
    step("alu");
    chk("alu_data", bus.wb_data, 64'h1234);
    chk("alu_cnt", bus.retire_count, 64'd1);
    drive(1, 1, 1, 3, 3'b000, 64'h1007, RD, 0, 0); step("lb7");
    chk("lb7_val", bus.wb_data, 64'hFFFFFFFFFFFFFF88);
    drive(1, 1, 1, 3, 3'b100, 64'h1007, RD, 0, 0); step("lbu7");
    chk("lbu7_val", bus.wb_data, 64'h88);
    drive(1, 1, 1, 3, 3'b001, 64'h1002, RD, 0, 0); step("lh2");
    chk("lh2_val", bus.wb_data, 64'h4433);
    drive(1, 1, 1, 3, 3'b010, 64'h1004, RD, 0, 0); step("lw4");
    chk("lw4_val", bus.wb_data, 64'hFFFFFFFF88776655);
    drive(1, 1, 1, 3, 3'b110, 64'h1004, RD, 0, 0); step("lwu4");
    chk("lwu4_val", bus.wb_data, 64'h88776655);
    drive(1, 1, 1, 3, 3'b011, 64'h1000, RD, 0, 0); step("ld0");
    chk("ld0_val", bus.wb_data, RD);
    drive(1, 1, 1, 7, 3'b001, 64'h1001, RD, 0, 0); step("lh1_mis");
    chk("lh1_mis_err", 64'(bus.misalign_err), 64'd1);
    chk("lh1_mis_we", 64'(bus.wb_we), 64'd0);
    drive(1, 1, 1, 7, 3'b010, 64'h1002, RD, 0, 0); step("lw2_mis");
    drive(1, 1, 1, 7, 3'b111, 64'h1000, RD, 0, 0); step("f3_7_mis");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("bubble_after_mis");
    chk("mis_pulse_end", 64'(bus.misalign_err), 64'd0);
    drive(1, 1, 0, 0, 0, 64'hFF, 0, 0, 0); step("rd0");
    chk("rd0_we", 64'(bus.wb_we), 64'd0);
    drive(1, 1, 0, 9, 0, 64'hABCD, 0, 0, 0); step("pre_stall");
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 4, 0, 64'h5555 + 64'(i), 0, 1, 0);
      step("stall");
    end
    chk("stall_data", bus.wb_data, 64'hABCD);
    drive(1, 1, 0, 4, 0, 64'h7777, 0, 1, 1); step("stall_flush");
    chk("flush_valid", 64'(bus.wb_valid), 64'd0);
    drive(1, 1, 1, 2, 3'b001, 64'h1003, RD, 0, 0); step("mis_then_stall");
    drive(1, 1, 0, 2, 0, 64'h1, 0, 1, 0); step("stall_clears_mis");
    drive(1, 1, 0, 6, 0, 64'h99, 0, 0, 0); step("pre_reset");
    chk("pre_reset_we", 64'(bus.wb_we), 64'd1);
    #2 rst = 1'b0;
    model_reset();
    #1 check_all("async_reset");
    @(negedge clk) rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("post_reset");
    force dut.r_retire = 64'hFFFFFFFFFFFFFFFF;
    e_cnt = 64'hFFFFFFFFFFFFFFFF;
    #1 chk("forced_cnt", bus.retire_count, e_cnt);
    release dut.r_retire;
    drive(1, 0, 0, 1, 0, 64'h3, 0, 0, 0); step("wrap");
    chk("wrap_cnt", bus.retire_count, 64'd0);
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)), 3'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      step("rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
